// File: rtl/riscv_aes_ctrl_pkg.sv
// Shared types and constants for the RISC-V AES instruction sequencer.
package riscv_aes_pkg;

   localparam int AES_WORDS       = 4;
   localparam int AES_ERR_LOAD    = 0;
   localparam int AES_ERR_TIMEOUT = 1;

   typedef enum logic [1:0] {
      SEL_DATA   = 2'd0,
      SEL_KEY    = 2'd1,
      SEL_START  = 2'd2,
      SEL_WBADDR = 2'd3
   } aes_sel_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_WB_REQ,
      ST_WB_RSP,
      ST_DONE
   } aes_ctrl_state_e;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_REQ,
      WB_RSP
   } wb_state_e;

   // Byte address of result word k; wraps at 32 bits.
   function automatic logic [31:0] wb_word_addr(input logic [31:0] base, input logic [1:0] k);
      return base + {28'd0, k, 2'b00};
   endfunction

endpackage

// File: rtl/riscv_aes_ctrl_if.sv
// Bundle of decode, register-file, AES-core and store-bus signals of the AES sequencer.
// Handshakes: an instruction is taken on a clk edge with instr_valid_i && instr_ready_o; a store
// request holds mem_req_o/mem_addr_o/mem_wdata_o stable until the edge with mem_gnt_i, and its
// single response (mem_rvalid_i) arrives at least one cycle after that grant.
interface riscv_aes_ctrl_if;
   import riscv_aes_pkg::*;

   logic            instr_valid_i;
   logic [1:0]      instr_sel_i;
   logic [1:0]      instr_idx_i;
   logic [31:0]     instr_wdata_i;
   logic            instr_ready_o;
   logic            rf_wen_o;
   logic [1:0]      rf_waddr_o;
   logic [31:0]     rf_wdata_o;
   logic [1:0]      rf_sel_o;
   logic            aes_start_o;
   logic            aes_done_i;
   logic [127:0]    aes_result_i;
   logic            mem_req_o;
   logic [31:0]     mem_addr_o;
   logic [31:0]     mem_wdata_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic            busy_o;
   logic            done_o;
   logic [1:0]      err_o;
   aes_ctrl_state_e dbg_state;
   wb_state_e       dbg_wb_state;
   logic [3:0]      dbg_data_mask;
   logic [3:0]      dbg_key_mask;
   logic            dbg_wb_loaded;

   modport slave (
      input  instr_valid_i, instr_sel_i, instr_idx_i, instr_wdata_i,
      input  aes_done_i, aes_result_i, mem_gnt_i, mem_rvalid_i,
      output instr_ready_o, rf_wen_o, rf_waddr_o, rf_wdata_o, rf_sel_o,
      output aes_start_o, mem_req_o, mem_addr_o, mem_wdata_o,
      output busy_o, done_o, err_o,
      output dbg_state, dbg_wb_state, dbg_data_mask, dbg_key_mask, dbg_wb_loaded
   );

   modport master (
      output instr_valid_i, instr_sel_i, instr_idx_i, instr_wdata_i,
      output aes_done_i, aes_result_i, mem_gnt_i, mem_rvalid_i,
      input  instr_ready_o, rf_wen_o, rf_waddr_o, rf_wdata_o, rf_sel_o,
      input  aes_start_o, mem_req_o, mem_addr_o, mem_wdata_o,
      input  busy_o, done_o, err_o,
      input  dbg_state, dbg_wb_state, dbg_data_mask, dbg_key_mask, dbg_wb_loaded
   );

endinterface

// File: rtl/riscv_aes_ctrl_wb_master.sv
// Writes a latched 128-bit result as four sequential 32-bit stores, one outstanding at a time.
module riscv_aes_wb_master
   import riscv_aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [31:0]  base_addr,
   input  logic [127:0] result,
   input  logic         mem_gnt,
   input  logic         mem_rvalid,
   output logic         mem_req,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   output logic         last,
   output wb_state_e    state_dbg
);

   wb_state_e    state, state_n;
   logic [1:0]   k;
   logic [31:0]  base;
   logic [127:0] words;
   logic         final_word;

   assign final_word = (k == 2'(AES_WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= WB_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         WB_IDLE: if (start)      state_n = WB_REQ;
         WB_REQ:  if (mem_gnt)    state_n = WB_RSP;
         WB_RSP:  if (mem_rvalid) state_n = final_word ? WB_IDLE : WB_REQ;
         default:                 state_n = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k     <= 2'd0;
         base  <= 32'd0;
         words <= 128'd0;
      end else if (state == WB_IDLE && start) begin
         k     <= 2'd0;
         base  <= base_addr;
         words <= result;
      end else if (state == WB_RSP && mem_rvalid && !final_word) begin
         k <= k + 2'd1;
      end
   end

   always_comb begin
      mem_req   = (state == WB_REQ);
      mem_addr  = mem_req ? wb_word_addr(base, k) : 32'd0;
      mem_wdata = mem_req ? words[{k, 5'b00000} +: 32] : 32'd0;
      last      = (state == WB_RSP) && mem_rvalid && final_word;
      state_dbg = state;
   end

endmodule

// File: rtl/riscv_aes_ctrl.sv
// AES custom-instruction sequencer: operand loads, core start/timeout, result writeback and stall.
module riscv_aes_ctrl
   import riscv_aes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DATA_WIDTH     = 32
) (
   input logic              clk,
   input logic              rst,
   riscv_aes_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   aes_ctrl_state_e        state, state_n;
   aes_sel_e               sel;
   logic [AES_WORDS-1:0]   data_mask, key_mask;
   logic                   wb_loaded;
   logic [DATA_WIDTH-1:0]  wb_addr;
   logic [1:0]             err;
   logic [CNT_W-1:0]       tmo_cnt, tmo_inc;
   logic                   accept, all_loaded, timeout;
   logic                   wb_start, wb_last, wb_req;
   logic [31:0]            wb_mem_addr, wb_mem_wdata;
   logic [31:0]            aligned_wdata;
   wb_state_e              wb_state;

   assign sel           = aes_sel_e'(bus.instr_sel_i);
   assign accept        = bus.instr_valid_i && (state == ST_IDLE);
   assign all_loaded    = (&data_mask) && (&key_mask) && wb_loaded;
   assign tmo_inc       = tmo_cnt + CNT_W'(1);
   assign timeout       = (tmo_inc == CNT_W'(TIMEOUT_CYCLES));
   assign wb_start      = (state == ST_WAIT) && bus.aes_done_i;
   assign aligned_wdata = {bus.instr_wdata_i[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (accept && sel == SEL_START && all_loaded) state_n = ST_START;
         ST_START:  state_n = ST_WAIT;
         ST_WAIT: begin
            if (bus.aes_done_i) state_n = ST_WB_REQ;
            else if (timeout)   state_n = ST_DONE;
         end
         ST_WB_REQ: if (bus.mem_gnt_i) state_n = ST_WB_RSP;
         ST_WB_RSP: if (bus.mem_rvalid_i) state_n = wb_last ? ST_DONE : ST_WB_REQ;
         ST_DONE:   state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // Load tracking, error flags and the done-wait timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_mask <= '0;
         key_mask  <= '0;
         wb_loaded <= 1'b0;
         wb_addr   <= '0;
         err       <= 2'b00;
         tmo_cnt   <= '0;
      end else begin
         if (accept) begin
            case (sel)
               SEL_DATA:   data_mask[bus.instr_idx_i] <= 1'b1;
               SEL_KEY:    key_mask[bus.instr_idx_i]  <= 1'b1;
               SEL_WBADDR: begin
                  wb_loaded <= 1'b1;
                  wb_addr   <= aligned_wdata;
               end
               default: begin
                  if (all_loaded) err <= 2'b00;
                  else            err[AES_ERR_LOAD] <= 1'b1;
               end
            endcase
         end
         if (state == ST_START) tmo_cnt <= '0;
         if (state == ST_WAIT && !bus.aes_done_i) begin
            tmo_cnt <= tmo_inc;
            if (timeout) err[AES_ERR_TIMEOUT] <= 1'b1;
         end
         // Key and writeback address survive for the next block; data must be reloaded.
         if (state == ST_DONE) data_mask <= '0;
      end
   end

   riscv_aes_wb_master u_wb (
      .clk        (clk),
      .rst        (rst),
      .start      (wb_start),
      .base_addr  (wb_addr),
      .result     (bus.aes_result_i),
      .mem_gnt    (bus.mem_gnt_i),
      .mem_rvalid (bus.mem_rvalid_i),
      .mem_req    (wb_req),
      .mem_addr   (wb_mem_addr),
      .mem_wdata  (wb_mem_wdata),
      .last       (wb_last),
      .state_dbg  (wb_state)
   );

   always_comb begin
      bus.instr_ready_o = (state == ST_IDLE);
      bus.rf_wen_o      = accept && (sel != SEL_START);
      bus.rf_waddr_o    = bus.rf_wen_o ? bus.instr_idx_i : 2'd0;
      bus.rf_sel_o      = bus.rf_wen_o ? bus.instr_sel_i : 2'd0;
      bus.rf_wdata_o    = 32'd0;
      if (bus.rf_wen_o)
         bus.rf_wdata_o = (sel == SEL_WBADDR) ? aligned_wdata : bus.instr_wdata_i;
      bus.aes_start_o   = (state == ST_START);
      bus.mem_req_o     = wb_req;
      bus.mem_addr_o    = wb_mem_addr;
      bus.mem_wdata_o   = wb_mem_wdata;
      bus.busy_o        = (state != ST_IDLE);
      bus.done_o        = (state == ST_DONE);
      bus.err_o         = err;
      bus.dbg_state     = state;
      bus.dbg_wb_state  = wb_state;
      bus.dbg_data_mask = data_mask;
      bus.dbg_key_mask  = key_mask;
      bus.dbg_wb_loaded = wb_loaded;
   end

endmodule

// File: tb/tb_riscv_aes_ctrl.sv
// Directed bench for riscv_aes_ctrl: operand-write table plus multi-cycle operation sequences.
module tb_riscv_aes_ctrl;
   import riscv_aes_pkg::*;

   logic clk, rst;
   riscv_aes_ctrl_if bus ();

   riscv_aes_ctrl #(.TIMEOUT_CYCLES(64), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  sel;
      logic [1:0]  idx;
      logic [31:0] wdata;
      logic        exp_wen;
      logic [1:0]  exp_sel;
      logic [1:0]  exp_waddr;
      logic [31:0] exp_wdata;
   } vec_t;

   localparam logic [127:0] KEY  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] PT1  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] CT1  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
   localparam logic [127:0] PT2  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] CT2  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
   localparam logic [127:0] CT3  = 128'hcafef00d_0badf00d_12345678_9abcdef0;
   localparam logic [31:0]  BASE = 32'h1000_0000;

   int          n_cmp = 0, n_err = 0;
   logic [63:0] exp_q[$];
   vec_t        vecs[10];
   int          hold_word = -1, hold_cycles = 0, hold_cnt = 0, hold_total = 0;
   int          store_cnt = 0, req_cycles = 0, unstable = 0, ready_bad = 0;
   logic        pending = 1'b0, seen_req = 1'b0;
   logic [31:0] first_addr = '0, first_wdata = '0;
   int          lat;
   logic        found;

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder and store scoreboard
   initial begin
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (bus.busy_o && bus.instr_ready_o) ready_bad++;
         if (rst) begin
            pending = 1'b0; seen_req = 1'b0; hold_cnt = 0;
            bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
         end else begin
            bus.mem_rvalid_i = pending;
            pending          = 1'b0;
            bus.mem_gnt_i    = 1'b0;
            if (bus.mem_req_o) begin
               req_cycles++;
               if (!seen_req) begin
                  first_addr = bus.mem_addr_o; first_wdata = bus.mem_wdata_o; seen_req = 1'b1;
               end else if (bus.mem_addr_o !== first_addr || bus.mem_wdata_o !== first_wdata) begin
                  unstable++;
               end
               if (store_cnt == hold_word && hold_cnt < hold_cycles) begin
                  hold_cnt++;
                  hold_total++;
               end else begin
                  bus.mem_gnt_i = 1'b1;
                  pending = 1'b1; seen_req = 1'b0; hold_cnt = 0;
                  if (exp_q.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL store_unexpected: got %0h/%0h expected none", bus.mem_addr_o, bus.mem_wdata_o);
                  end else begin
                     check("store", {bus.mem_addr_o, bus.mem_wdata_o}, exp_q.pop_front());
                  end
                  store_cnt++;
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic issue(input logic [1:0] sel, input logic [1:0] idx, input logic [31:0] wdata);
      @(negedge clk);
      bus.instr_valid_i = 1'b1; bus.instr_sel_i = sel; bus.instr_idx_i = idx; bus.instr_wdata_i = wdata;
      @(posedge clk);
      #1 bus.instr_valid_i = 1'b0;
   endtask

   task automatic load_data(input logic [127:0] d);
      for (int i = 0; i < 4; i++) issue(SEL_DATA, 2'(i), d[32*i +: 32]);
   endtask

   task automatic push_exp(input logic [31:0] base, input logic [127:0] res, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({base + 32'(4 * k), res[32*k +: 32]});
   endtask

   // Issues start, models the core answering after 'delay' cycles, returns cycles to done_o.
   task automatic run_op(input logic [127:0] res, input int delay, input bit give_done, output int lat_o);
      lat_o = -1;
      store_cnt = 0;
      issue(SEL_START, 2'd0, 32'd0);
      @(negedge clk); #1;
      check("start_pulse", bus.aes_start_o, 1'b1);
      check("busy_on_start", bus.busy_o, 1'b1);
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (give_done && n == delay) begin
            bus.aes_done_i = 1'b1; bus.aes_result_i = res;
         end else begin
            bus.aes_done_i = 1'b0;
         end
         #1;
         if (n == 1) check("start_one_cycle", bus.aes_start_o, 1'b0);
         if (bus.done_o) begin
            lat_o = n;
            break;
         end
      end
      bus.aes_done_i = 1'b0;
      @(negedge clk); #1;
      check("done_one_cycle", bus.done_o, 1'b0);
      check("idle_ready", bus.instr_ready_o, 1'b1);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      rst = 1'b1;
      bus.instr_valid_i = 1'b0; bus.instr_sel_i = 2'd0; bus.instr_idx_i = 2'd0; bus.instr_wdata_i = 32'd0;
      bus.aes_done_i = 1'b0; bus.aes_result_i = 128'd0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_state", bus.dbg_state, ST_IDLE);
      check("rst_ready", bus.instr_ready_o, 1'b1);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_start", bus.aes_start_o, 1'b0);
      check("rst_done", bus.done_o, 1'b0);
      check("rst_mem_req", bus.mem_req_o, 1'b0);
      check("rst_err", bus.err_o, 2'b00);
      check("rst_rf_wen", bus.rf_wen_o, 1'b0);
      check("rst_masks", {bus.dbg_data_mask, bus.dbg_key_mask, bus.dbg_wb_loaded}, 9'd0);
      rst = 1'b0;

      // Operand writes: a rewritten data word, the key, the data and an unaligned wb address.
      vecs[0] = '{SEL_DATA,   2'd0, 32'hdeadbeef,  1'b1, 2'd0, 2'd0, 32'hdeadbeef};
      vecs[1] = '{SEL_KEY,    2'd0, 32'h0c0d0e0f,  1'b1, 2'd1, 2'd0, 32'h0c0d0e0f};
      vecs[2] = '{SEL_KEY,    2'd1, 32'h08090a0b,  1'b1, 2'd1, 2'd1, 32'h08090a0b};
      vecs[3] = '{SEL_KEY,    2'd2, 32'h04050607,  1'b1, 2'd1, 2'd2, 32'h04050607};
      vecs[4] = '{SEL_KEY,    2'd3, 32'h00010203,  1'b1, 2'd1, 2'd3, 32'h00010203};
      vecs[5] = '{SEL_DATA,   2'd0, 32'hccddeeff,  1'b1, 2'd0, 2'd0, 32'hccddeeff};
      vecs[6] = '{SEL_DATA,   2'd1, 32'h8899aabb,  1'b1, 2'd0, 2'd1, 32'h8899aabb};
      vecs[7] = '{SEL_DATA,   2'd2, 32'h44556677,  1'b1, 2'd0, 2'd2, 32'h44556677};
      vecs[8] = '{SEL_DATA,   2'd3, 32'h00112233,  1'b1, 2'd0, 2'd3, 32'h00112233};
      vecs[9] = '{SEL_WBADDR, 2'd2, 32'h1000_0003, 1'b1, 2'd3, 2'd2, 32'h1000_0000};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.instr_valid_i = 1'b1; bus.instr_sel_i = vecs[i].sel;
         bus.instr_idx_i = vecs[i].idx; bus.instr_wdata_i = vecs[i].wdata;
         #1;
         check("tbl_rf_wen", bus.rf_wen_o, vecs[i].exp_wen);
         check("tbl_rf_sel", bus.rf_sel_o, vecs[i].exp_sel);
         check("tbl_rf_waddr", bus.rf_waddr_o, vecs[i].exp_waddr);
         check("tbl_rf_wdata", bus.rf_wdata_o, vecs[i].exp_wdata);
         check("tbl_ready", bus.instr_ready_o, 1'b1);
         @(posedge clk);
         #1 bus.instr_valid_i = 1'b0;
      end
      check("loaded_masks", {bus.dbg_data_mask, bus.dbg_key_mask, bus.dbg_wb_loaded}, 9'h1ff);

      // Full operation, core answers 10 cycles after start.
      push_exp(BASE, CT1, 4);
      run_op(CT1, 10, 1'b1, lat);
      check("op1_latency", 128'(lat), 128'd19);
      check("op1_stores", 128'(store_cnt), 128'd4);
      check("op1_exp_empty", 128'(exp_q.size()), 128'd0);
      check("op1_err", bus.err_o, 2'b00);
      check("op1_masks_after", {bus.dbg_data_mask, bus.dbg_key_mask, bus.dbg_wb_loaded}, 9'h01f);

      // Start with data word 3 missing.
      for (int i = 0; i < 3; i++) issue(SEL_DATA, 2'(i), PT2[32*i +: 32]);
      check("partial_mask", bus.dbg_data_mask, 4'b0111);
      issue(SEL_START, 2'd0, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         check("nostart_pulse", bus.aes_start_o, 1'b0);
         check("nostart_ready", bus.instr_ready_o, 1'b1);
      end
      check("nostart_err", bus.err_o, 2'b01);
      check("nostart_state", bus.dbg_state, ST_IDLE);

      // New data only, retained key and address; grant withheld 5 cycles on word 2.
      load_data(PT2);
      hold_word = 2; hold_cycles = 5; hold_total = 0; unstable = 0; ready_bad = 0;
      push_exp(BASE, CT2, 4);
      run_op(CT2, 4, 1'b1, lat);
      hold_word = -1;
      check("op2_latency", 128'(lat), 128'd18);
      check("op2_hold_cycles", 128'(hold_total), 128'd5);
      check("op2_stable", 128'(unstable), 128'd0);
      check("op2_ready_low", 128'(ready_bad), 128'd0);
      check("op2_stores", 128'(store_cnt), 128'd4);
      check("op2_exp_empty", 128'(exp_q.size()), 128'd0);
      check("op2_err", bus.err_o, 2'b00);

      // Core never answers.
      load_data(PT1);
      req_cycles = 0;
      run_op(128'd0, 0, 1'b0, lat);
      check("tmo_latency", 128'(lat), 128'd65);
      check("tmo_err", bus.err_o, 2'b10);
      check("tmo_no_req", 128'(req_cycles), 128'd0);

      // Reset while waiting for the third store's response.
      load_data(PT1);
      push_exp(BASE, CT3, 3);
      store_cnt = 0;
      found = 1'b0;
      issue(SEL_START, 2'd0, 32'd0);
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         bus.aes_done_i = (n == 3);
         bus.aes_result_i = CT3;
         #1;
         if (bus.dbg_state == ST_WB_RSP && store_cnt == 3) begin
            found = 1'b1;
            break;
         end
      end
      bus.aes_done_i = 1'b0;
      check("rst_point_reached", found, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_state", bus.dbg_state, ST_IDLE);
      check("midrst_masks", {bus.dbg_data_mask, bus.dbg_key_mask, bus.dbg_wb_loaded}, 9'd0);
      check("midrst_busy", bus.busy_o, 1'b0);
      check("midrst_ready", bus.instr_ready_o, 1'b1);
      check("midrst_exp_empty", 128'(exp_q.size()), 128'd0);
      req_cycles = 0;
      repeat (20) @(negedge clk);
      #3;
      check("midrst_no_req", 128'(req_cycles), 128'd0);
      check("midrst_stores", 128'(store_cnt), 128'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
